// File: rtl/steer_input.sv
`default_nettype none
// ============================================================================
//  Module   : steer_input
//  Purpose  : Player-control front end for the CPU input window 0x0200-0x0207.
//             Synchronises and debounces the cabinet switches, filters and
//             decodes the steering-wheel quadrature optics into a step
//             accumulator, a steer flag and a direction latch, and drives
//             the 8-bit read data for the input window.
//  Ports    : Clk6          6 MHz system clock (rising edge)
//             Reset_n       asynchronous active-low reset
//             Steer_A/B     raw quadrature phases
//             Gas_n, Start_n, TrakSel_n, Test_n, Coin1_n, Coin2_n
//                           raw active-low switches
//             SteerReset_n  CPU strobe clearing flag and accumulator
//             In1_n, Adr    CPU input-window select and address bits 2:0
//             DBus_in       read data ({bit, 7'b1111111} or 8'hFF)
//             SteerFlag     steer flag (debug)
//             SteerDir      direction latch (debug)
//  Revision : 1.0  initial release
// ============================================================================
module steer_input #(
    parameter int DEB_CYCLES = 4096,
    parameter int QF_CYCLES  = 8,
    parameter int CNT_W      = 4
) (
    input  logic       Clk6,
    input  logic       Reset_n,
    input  logic       Steer_A,
    input  logic       Steer_B,
    input  logic       Gas_n,
    input  logic       Start_n,
    input  logic       TrakSel_n,
    input  logic       Test_n,
    input  logic       Coin1_n,
    input  logic       Coin2_n,
    input  logic       SteerReset_n,
    input  logic       In1_n,
    input  logic [2:0] Adr,
    output logic [7:0] DBus_in,
    output logic       SteerFlag,
    output logic       SteerDir
);

    localparam int c_NUM_SW   = 6;
    localparam int c_SYNC_W   = 9;
    localparam int c_IDX_A    = 6;
    localparam int c_IDX_SRST = 8;
    localparam int c_DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_QF_W     = (QF_CYCLES > 1) ? $clog2(QF_CYCLES) : 1;

    localparam logic [c_DEB_W-1:0]      c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_QF_W-1:0]       c_QF_LAST  = c_QF_W'(QF_CYCLES - 1);
    localparam logic signed [CNT_W-1:0] c_ACC_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] c_ACC_MIN  = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic signed [CNT_W-1:0] c_ACC_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-stage synchronisers for every raw input.
    // Bit map: 0..5 switches (Gas, Start, TrakSel, Test, Coin1, Coin2),
    //          6 = Steer_A, 7 = Steer_B, 8 = SteerReset_n.
    // ------------------------------------------------------------------
    logic [c_SYNC_W-1:0] w_raw;
    logic [c_SYNC_W-1:0] r_sync1;
    logic [c_SYNC_W-1:0] r_sync2;

    assign w_raw = {SteerReset_n, Steer_B, Steer_A,
                    Coin2_n, Coin1_n, Test_n, TrakSel_n, Start_n, Gas_n};

    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Switch debounce: the counter measures how long the synced level has
    // disagreed with the debounced level; the level flips only after
    // DEB_CYCLES consecutive disagreeing cycles.
    // ------------------------------------------------------------------
    logic [c_DEB_W-1:0]  r_sw_cnt [c_NUM_SW];
    logic [c_NUM_SW-1:0] r_sw_lvl;

    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < c_NUM_SW; i++) begin
                r_sw_cnt[i] <= '0;
            end
            r_sw_lvl <= '1;
        end else begin
            for (int i = 0; i < c_NUM_SW; i++) begin
                if (r_sync2[i] == r_sw_lvl[i]) begin
                    r_sw_cnt[i] <= '0;
                end else if (r_sw_cnt[i] == c_DEB_LAST) begin
                    r_sw_lvl[i] <= r_sync2[i];
                    r_sw_cnt[i] <= '0;
                end else begin
                    r_sw_cnt[i] <= r_sw_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Quadrature phase filter, same scheme with a short window.
    // r_qf_lvl[0] = fA, r_qf_lvl[1] = fB.
    // ------------------------------------------------------------------
    logic [c_QF_W-1:0] r_qf_cnt [2];
    logic [1:0]        r_qf_lvl;

    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_qf_cnt[i] <= '0;
            end
            r_qf_lvl <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[c_IDX_A+i] == r_qf_lvl[i]) begin
                    r_qf_cnt[i] <= '0;
                end else if (r_qf_cnt[i] == c_QF_LAST) begin
                    r_qf_lvl[i] <= r_sync2[c_IDX_A+i];
                    r_qf_cnt[i] <= '0;
                end else begin
                    r_qf_cnt[i] <= r_qf_cnt[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Quadrature decoder. Clockwise Gray order is 00->01->11->10->00.
    // A two-bit jump matches neither list and produces no step.
    // ------------------------------------------------------------------
    logic [1:0] w_qcur;
    logic [1:0] r_qprev;
    logic       w_step_up;
    logic       w_step_dn;

    assign w_qcur = {r_qf_lvl[0], r_qf_lvl[1]};

    always_comb begin
        w_step_up = 1'b0;
        w_step_dn = 1'b0;
        case ({r_qprev, w_qcur})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_step_up = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: w_step_dn = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Step accumulator, flag and direction. The synced SteerReset_n level
    // has priority, so a step landing in a strobe cycle is dropped and the
    // direction latch is left untouched.
    // ------------------------------------------------------------------
    logic                    w_srst_act;
    logic signed [CNT_W-1:0] r_acc;
    logic                    r_flag;
    logic                    r_dir;

    assign w_srst_act = ~r_sync2[c_IDX_SRST];

    always_ff @(posedge Clk6 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_qprev <= 2'b11;
            r_acc   <= '0;
            r_flag  <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_qprev <= w_qcur;
            if (w_srst_act) begin
                r_acc  <= '0;
                r_flag <= 1'b0;
            end else if (w_step_up) begin
                r_flag <= 1'b1;
                r_dir  <= 1'b1;
                if (r_acc != c_ACC_MAX) begin
                    r_acc <= r_acc + c_ACC_ONE;
                end
            end else if (w_step_dn) begin
                r_flag <= 1'b1;
                r_dir  <= 1'b0;
                if (r_acc != c_ACC_MIN) begin
                    r_acc <= r_acc - c_ACC_ONE;
                end
            end
        end
    end

    assign SteerFlag = r_flag;
    assign SteerDir  = r_dir;

    // ------------------------------------------------------------------
    // Read mux: only bit 7 carries data; the rest float high.
    // ------------------------------------------------------------------
    logic w_sel;

    always_comb begin
        w_sel = 1'b1;
        case (Adr)
            3'd0: w_sel = ~r_flag;
            3'd1: w_sel = r_dir;
            3'd2: w_sel = r_sw_lvl[0];
            3'd3: w_sel = r_sw_lvl[1];
            3'd4: w_sel = r_sw_lvl[2];
            3'd5: w_sel = r_sw_lvl[3];
            3'd6: w_sel = r_sw_lvl[4];
            3'd7: w_sel = r_sw_lvl[5];
        endcase
        DBus_in = In1_n ? 8'hFF : {w_sel, 7'b1111111};
    end

endmodule
`default_nettype wire

// File: tb/tb_steer_input.sv
`timescale 1ns/1ns
`default_nettype none
// ============================================================================
//  Module   : tb_steer_input
//  Purpose  : Self-checking bench for steer_input: directed scenarios plus
//             randomized switch / quadrature / strobe activity compared
//             against a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_steer_input;

    localparam int DEB     = 256;
    localparam int QF      = 8;
    localparam int CW      = 4;
    localparam int ACC_MAX = (1 << (CW - 1)) - 1;
    localparam int ACC_MIN = -(1 << (CW - 1));

    logic       Clk6   = 1'b0;
    bit         clk_en = 1'b1;
    logic       Reset_n;
    logic       Steer_A;
    logic       Steer_B;
    logic [5:0] sw_n;
    logic       SteerReset_n;
    logic       In1_n;
    logic [2:0] Adr;
    logic [7:0] DBus_in;
    logic       SteerFlag;
    logic       SteerDir;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] c_SWEEP [8] = '{8'hFF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    always begin
        #5;
        if (clk_en) Clk6 = ~Clk6;
    end

    steer_input #(
        .DEB_CYCLES (DEB),
        .QF_CYCLES  (QF),
        .CNT_W      (CW)
    ) dut (
        .Clk6         (Clk6),
        .Reset_n      (Reset_n),
        .Steer_A      (Steer_A),
        .Steer_B      (Steer_B),
        .Gas_n        (sw_n[0]),
        .Start_n      (sw_n[1]),
        .TrakSel_n    (sw_n[2]),
        .Test_n       (sw_n[3]),
        .Coin1_n      (sw_n[4]),
        .Coin2_n      (sw_n[5]),
        .SteerReset_n (SteerReset_n),
        .In1_n        (In1_n),
        .Adr          (Adr),
        .DBus_in      (DBus_in),
        .SteerFlag    (SteerFlag),
        .SteerDir     (SteerDir)
    );

    // ------------------------------------------------------------------
    // Reference model. Inputs seen two edges late; a level is accepted
    // once it has been seen unchanged for the required number of cycles;
    // steps come from the change of position around the Gray circle.
    // Index map: 0..5 switches, 6 = A, 7 = B, 8 = SteerReset_n.
    // ------------------------------------------------------------------
    logic [8:0] m_s1   = '1;
    logic [8:0] m_s2   = '1;
    logic [8:0] m_last = '1;
    logic [8:0] m_lvl  = '1;
    int         m_run [9];
    int         m_prev = 2;
    int         m_acc  = 0;
    logic       m_flag = 1'b0;
    logic       m_dir  = 1'b0;
    int         m_cur;
    int         m_d;
    int         m_lim;

    function automatic int gray_idx(input logic a, input logic b);
        case ({a, b})
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gray_code(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 9; i++) m_run[i] = 0;
        forever begin
            @(posedge Clk6 or negedge Reset_n);
            if (!Reset_n) begin
                m_s1 = '1; m_s2 = '1; m_last = '1; m_lvl = '1;
                for (int i = 0; i < 9; i++) m_run[i] = 0;
                m_prev = 2; m_acc = 0; m_flag = 1'b0; m_dir = 1'b0;
            end else begin
                m_cur = gray_idx(m_lvl[6], m_lvl[7]);
                m_d   = (m_cur - m_prev + 4) % 4;
                if (!m_s2[8]) begin
                    m_acc  = 0;
                    m_flag = 1'b0;
                end else if (m_d == 1) begin
                    m_flag = 1'b1;
                    m_dir  = 1'b1;
                    if (m_acc < ACC_MAX) m_acc = m_acc + 1;
                end else if (m_d == 3) begin
                    m_flag = 1'b1;
                    m_dir  = 1'b0;
                    if (m_acc > ACC_MIN) m_acc = m_acc - 1;
                end
                m_prev = m_cur;
                for (int i = 0; i < 8; i++) begin
                    if (m_s2[i] == m_last[i]) begin
                        if (m_run[i] < 1000000) m_run[i] = m_run[i] + 1;
                    end else begin
                        m_last[i] = m_s2[i];
                        m_run[i]  = 1;
                    end
                    m_lim = (i < 6) ? DEB : QF;
                    if (m_run[i] >= m_lim && m_s2[i] != m_lvl[i]) m_lvl[i] = m_s2[i];
                end
                m_s2 = m_s1;
                m_s1 = {SteerReset_n, Steer_B, Steer_A, sw_n};
            end
        end
    end

    function automatic logic [7:0] exp_dbus(input logic in1n, input logic [2:0] a);
        logic b;
        if (in1n) return 8'hFF;
        case (a)
            3'd0:    b = ~m_flag;
            3'd1:    b = m_dir;
            default: b = m_lvl[a - 3'd2];
        endcase
        return {b, 7'b1111111};
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic read_adr(input logic [2:0] a, input logic [7:0] exp, input string tag);
        In1_n = 1'b0;
        Adr   = a;
        #1;
        chk(tag, {24'd0, DBus_in}, {24'd0, exp});
    endtask

    task automatic chk_state(input string tag, input logic flag, input logic dir, input int acc);
        chk({tag, "_flag"}, {31'd0, SteerFlag}, {31'd0, flag});
        chk({tag, "_dir"},  {31'd0, SteerDir},  {31'd0, dir});
        chk({tag, "_acc"},  {28'd0, dut.r_acc}, {28'd0, 4'(acc)});
    endtask

    task automatic check_model(input logic in1n, input logic [2:0] a);
        In1_n = in1n;
        Adr   = a;
        #1;
        chk("mdl_dbus", {24'd0, DBus_in}, {24'd0, exp_dbus(in1n, a)});
        chk_state("mdl", m_flag, m_dir, m_acc);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge Clk6);
    endtask

    task automatic quad(input logic [1:0] ab, input int hold);
        Steer_A = ab[1];
        Steer_B = ab[0];
        cycles(hold);
    endtask

    task automatic srst_pulse(input int w);
        SteerReset_n = 1'b0;
        cycles(w);
        SteerReset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int gi;
        int srst_left;
        int j;
        int r;

        Reset_n = 1'b0; sw_n = '1; Steer_A = 1'b1; Steer_B = 1'b1;
        SteerReset_n = 1'b1; In1_n = 1'b1; Adr = 3'd0;
        #22 Reset_n = 1'b1;
        @(negedge Clk6);

        // Reset state and idle read sweep
        for (int a = 0; a < 8; a++) begin
            read_adr(3'(a), c_SWEEP[a], "rst_sweep");
            @(negedge Clk6);
        end
        In1_n = 1'b1; Adr = 3'd2; #1;
        chk("in1_high", {24'd0, DBus_in}, 32'hFF);
        chk_state("rst", 1'b0, 1'b0, 0);

        // Glitch shorter than the debounce window is never seen
        @(negedge Clk6);
        sw_n[0] = 1'b0;
        for (int k = 0; k < DEB - 10; k++) begin
            @(negedge Clk6);
            if (k % 32 == 0) read_adr(3'd2, 8'hFF, "gas_glitch");
        end
        sw_n[0] = 1'b1;
        for (int k = 0; k < DEB + 10; k++) begin
            @(negedge Clk6);
            if (k % 32 == 0) read_adr(3'd2, 8'hFF, "gas_glitch_after");
        end

        // Exact debounce latency 2 + DEB
        sw_n[0] = 1'b0;
        cycles(DEB + 1);
        read_adr(3'd2, 8'hFF, "gas_lat_early");
        @(negedge Clk6);
        read_adr(3'd2, 8'h7F, "gas_lat");
        check_model(1'b0, 3'd2);
        sw_n[0] = 1'b1;
        cycles(DEB + 5);
        read_adr(3'd2, 8'hFF, "gas_release");

        // Four clockwise steps from 11
        quad(2'b10, 20); quad(2'b00, 20); quad(2'b01, 20); quad(2'b11, 20);
        chk_state("cw4", 1'b1, 1'b1, 4);
        read_adr(3'd0, 8'h7F, "cw4_adr0");
        @(negedge Clk6);
        read_adr(3'd1, 8'hFF, "cw4_adr1");

        // Steer reset strobe, then one counter-clockwise step
        srst_pulse(4);
        cycles(6);
        chk_state("srst", 1'b0, 1'b1, 0);
        quad(2'b01, 20);
        chk_state("ccw1", 1'b1, 1'b0, -1);

        // Step qualifying in the same cycle as the synced strobe
        Steer_A = 1'b1; Steer_B = 1'b1;
        cycles(QF);
        SteerReset_n = 1'b0;
        cycles(1);
        SteerReset_n = 1'b1;
        cycles(12);
        chk_state("coinc", 1'b0, 1'b0, 0);

        // Illegal two-bit jump 00 -> 11, then check the previous pair moved
        quad(2'b10, 20); quad(2'b00, 20);
        srst_pulse(4);
        cycles(6);
        quad(2'b11, 20);
        chk_state("illegal", 1'b0, 1'b1, 0);
        quad(2'b10, 20);
        chk_state("after_illegal", 1'b1, 1'b1, 1);
        check_model(1'b0, 3'd0);

        // Positive saturation, then negative saturation
        srst_pulse(4);
        cycles(6);
        gi = 3;
        for (int s = 0; s < 20; s++) begin
            gi = (gi + 1) % 4;
            quad(gray_code(gi), 20);
            chk("sat_pos_acc", {28'd0, dut.r_acc}, {28'd0, 4'((s + 1 < ACC_MAX) ? s + 1 : ACC_MAX)});
        end
        chk_state("sat_pos", 1'b1, 1'b1, ACC_MAX);
        for (int s = 0; s < 20; s++) begin
            gi = (gi + 3) % 4;
            quad(gray_code(gi), 20);
        end
        chk_state("sat_neg", 1'b1, 1'b0, ACC_MIN);

        // Async reset with the clock stopped, gas held through it
        sw_n[0] = 1'b0;
        cycles(DEB + 4);
        read_adr(3'd2, 8'h7F, "gas_held");
        @(negedge Clk6);
        clk_en = 1'b0;
        #2 Reset_n = 1'b0;
        #3;
        read_adr(3'd2, 8'hFF, "arst_gas");
        read_adr(3'd0, 8'hFF, "arst_adr0");
        read_adr(3'd1, 8'h7F, "arst_adr1");
        chk_state("arst", 1'b0, 1'b0, 0);
        Steer_A = 1'b1; Steer_B = 1'b1;
        #4 Reset_n = 1'b1;
        #1;
        while ($time % 5 == 0) #1;
        clk_en = 1'b1;
        cycles(DEB + 1);
        read_adr(3'd2, 8'hFF, "requal_early");
        @(negedge Clk6);
        read_adr(3'd2, 8'h7F, "requal");
        check_model(1'b0, 3'd2);
        sw_n[0] = 1'b1;
        cycles(DEB + 5);

        // Randomized activity against the reference model
        gi = 2;
        srst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge Clk6);
            if (c == 2001) begin
                #1 Reset_n = 1'b0;
                #1 Reset_n = 1'b1;
            end
            if ($urandom_range(39) == 0) begin
                j = $urandom_range(5);
                sw_n[j] = ~sw_n[j];
            end
            r = $urandom_range(99);
            if (r < 4)       gi = (gi + 1) % 4;
            else if (r < 8)  gi = (gi + 3) % 4;
            else if (r == 8) gi = (gi + 2) % 4;
            Steer_A = gray_code(gi)[1];
            Steer_B = gray_code(gi)[0];
            if (srst_left > 0) begin
                srst_left--;
                if (srst_left == 0) SteerReset_n = 1'b1;
            end else if ($urandom_range(149) == 0) begin
                SteerReset_n = 1'b0;
                srst_left = $urandom_range(4, 1);
            end
            if (c % 4 == 3) check_model($urandom_range(3) == 0, 3'($urandom_range(7)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/steer_input.md
Name: steer_input

Overview:
- Player-control front end feeding the CPU input read path (In1_n / DBus_in) of the Super Bug core.
- Synchronises and debounces raw cabinet switches.
- Decodes the steering-wheel quadrature optics into a steer flag and a direction latch; the CPU clears these with the SteerReset_n strobe.
- Drives the 8-bit read data for the 0x0200–0x0207 input window.

Parameters:
- DEB_CYCLES, 4096, Clk6 cycles a switch must be stable before its debounced level changes (~0.7 ms).
- QF_CYCLES, 8, Clk6 cycles each quadrature phase must be stable before it is accepted.
- CNT_W, 4, width of the signed step accumulator.

Ports:
- Clk6  in  1  6 MHz system clock; all state on rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Steer_A  in  1  raw steering quadrature phase A.
- Steer_B  in  1  raw steering quadrature phase B.
- Gas_n  in  1  raw gas pedal switch, active low.
- Start_n  in  1  raw start button, active low.
- TrakSel_n  in  1  raw track-select button, active low.
- Test_n  in  1  raw self-test switch, active low.
- Coin1_n  in  1  raw coin switch 1, active low.
- Coin2_n  in  1  raw coin switch 2, active low.
- SteerReset_n  in  1  CPU strobe, active low, one or more Clk6 cycles wide.
- In1_n  in  1  CPU input-window select, active low.
- Adr  in  3  CPU address bits 2:0.
- DBus_in  out  8  read data to the CPU data-in mux.
- SteerFlag  out  1  debug: steer flag.
- SteerDir  out  1  debug: direction latch.

Behaviour:
- Reset (Reset_n=0, async):
  - All synchronisers, filters and debounced levels go to 1 (inactive).
  - Debounce and filter counters go to 0.
  - Step accumulator = 0, SteerFlag = 0, SteerDir = 0.
  - Both stored quadrature phases = 1.
  - DBus_in follows the combinational rule below.
- Synchronisers:
  - Every raw input passes through a 2-FF synchroniser.
  - Pipeline latency before any filter: 2 cycles.
- Switch debounce (per input, independent):
  - Counter increments while the synced value ≠ debounced value; it clears when they are equal.
  - When the counter reaches DEB_CYCLES-1 and the value still differs, the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEB_CYCLES is never seen.
  - Latency from a clean edge: 2 + DEB_CYCLES cycles.
- Quadrature filter:
  - Same scheme as the switch debounce with QF_CYCLES, applied to A and B separately. This gives filtered phases fA and fB.
- Quadrature decoder:
  - Compares {fA,fB} with the previous pair each cycle.
  - Gray sequence 00→01→11→10→00 is one +1 step (clockwise, right).
  - The reverse sequence is one -1 step.
  - No change: no step.
  - Both bits changed (illegal): no step, and the previous pair is still updated.
- Step accumulator (signed CNT_W):
  - Saturates at +2^(CNT_W-1)-1 and -2^(CNT_W-1); it never wraps.
- Steer flag and direction:
  - Any step sets SteerFlag=1.
  - SteerDir is set to 1 on a +1 step and 0 on a -1 step (last step wins).
  - Accumulator nonzero implies SteerFlag=1.
- SteerReset_n handling:
  - SteerReset_n is synchronised (2 FF) and sampled as a level.
  - While it is low: accumulator=0 and SteerFlag=0; SteerDir holds.
  - A step that arrives in a cycle where the synced strobe is low is discarded (reset wins).
  - The first step after release sets the flag normally.
- Read mux (combinational):
  - When In1_n=0: DBus_in = {bit, 7'b1111111}, where bit is selected by Adr:
    - 0: ~SteerFlag
    - 1: SteerDir
    - 2: Gas debounced
    - 3: Start debounced
    - 4: TrakSel debounced
    - 5: Test debounced
    - 6: Coin1 debounced
    - 7: Coin2 debounced
  - When In1_n=1: DBus_in = 8'hFF.
  - Switch bits read 0 when pressed.
- Reset mid-operation:
  - Asserting Reset_n aborts any in-progress debounce or filter count.
  - Held switches must re-qualify for the full DEB_CYCLES after release of reset.

Test Plan:
- Reset, then In1_n=0 and sweep Adr 0..7 with all switches released → DBus_in = FF,7F,FF,FF,FF,FF,FF,FF.
- Gas_n low for DEB_CYCLES-10 cycles, then high → Adr=2 reads FF throughout. Gas_n held low → reads 7F exactly 2+DEB_CYCLES cycles after the edge.
- Four clockwise Gray steps, each phase stable 20 cycles → SteerFlag=1, SteerDir=1, Adr0 reads 7F, Adr1 reads FF, accumulator=+4.
- Pulse SteerReset_n low 4 cycles → SteerFlag=0 and accumulator=0, SteerDir stays 1. Then one counter-clockwise step → SteerFlag=1, SteerDir=0.
- A step qualifies in the same cycle as the synced SteerReset_n low → flag stays 0. A {fA,fB} jump 00→11 → no flag change.
- Twenty clockwise steps with no reset → accumulator saturates at +7 (CNT_W=4), no wrap. Reset_n pulsed mid-sequence → all state cleared asynchronously, including while the clock is stopped.
